// File: rtl/serial_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_addsub_pkg
// Brief    : Shared types and constants for the bit-serial add/sub unit.
// Revision : 1.0 - initial release
// ============================================================================
package serial_addsub_pkg;

    // Controller states: waiting for operands, shifting bits, holding result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default operand/result width
    localparam int c_default_width = 8;

endpackage
`default_nettype wire

// File: rtl/full_adder_cell.sv
`default_nettype none
// ============================================================================
// Module   : full_adder_cell
// Brief    : Single-bit combinational full adder; the one arithmetic
//            resource of the serial unit, reused on every RUN cycle.
// Revision : 1.0 - initial release
// ============================================================================
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic w_axb;

    assign w_axb = a ^ b;
    assign sum   = w_axb ^ cin;
    assign cout  = (a & b) | (cin & w_axb);

endmodule
`default_nettype wire

// File: rtl/serial_addsub_acc.sv
`default_nettype none
// ============================================================================
// Module   : serial_addsub_acc
// Brief    : Bit-serial adder/subtractor with optional accumulator. One
//            full-adder cell is walked across WIDTH bits, LSB first, with a
//            registered carry. Valid/ready handshakes on input and output.
// Revision : 1.0 - initial release
// ============================================================================
module serial_addsub_acc
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH  = c_default_width,
    parameter int ACC_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_sub,
    input  logic             op_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [WIDTH-1:0] acc_out,
    output logic             busy
);

    localparam int                 c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;

    logic               w_s;
    logic               w_c;
    logic [WIDTH-1:0]   w_res_next;
    logic [WIDTH-1:0]   w_acc;
    logic [WIDTH-1:0]   w_a_load;
    logic               w_finish;

    // The single arithmetic resource, fed by the LSBs of the shift registers
    full_adder_cell u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .sum  (w_s),
        .cout (w_c)
    );

    assign w_res_next = {w_s, r_res[WIDTH-1:1]};
    assign w_a_load   = (op_acc && (ACC_EN != 0)) ? w_acc : op_a;
    assign w_finish   = (r_state == RUN) && (r_cnt == c_last);

    // Accumulator exists only when enabled; it latches each completed result
    generate
        if (ACC_EN != 0) begin : g_acc
            logic [WIDTH-1:0] r_acc;

            // Capture the final result on the completing RUN edge only
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_acc <= '0;
                end else if (w_finish) begin
                    r_acc <= w_res_next;
                end
            end

            assign w_acc = r_acc;
        end else begin : g_no_acc
            assign w_acc = '0;
        end
    endgenerate

    // Controller and datapath: load operands, shift one bit per edge, hold result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        // Subtraction is A + ~B + 1: invert B and seed carry
                        r_a        <= w_a_load;
                        r_b        <= op_sub ? ~op_b : op_b;
                        r_carry    <= op_sub;
                        r_cnt      <= '0;
                        r_res      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_res   <= w_res_next;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_last) begin
                        // r_carry here is the carry into the MSB
                        r_sum       <= w_res_next;
                        r_cout      <= w_c;
                        r_ovf       <= r_carry ^ w_c;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign acc_out   = w_acc;

endmodule
`default_nettype wire
